// File: rtl/udt_hs_parser.sv
// UDT handshake parser: captures body words 4..15 of a handshake packet and
// emits them as client_* fields. Optional dropped-handshake counter: UDT_HS_DROP_CNT_EN.
module udt_hs_parser #(
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  in_ready,
    output logic                  client_type_en,
    output logic [31:0]           client_type,
    output logic [31:0]           client_version,
    output logic [31:0]           client_sock_type,
    output logic [31:0]           client_isn,
    output logic [31:0]           client_mss,
    output logic [31:0]           client_flow_win,
    output logic [31:0]           client_sock_id,
    output logic [31:0]           client_cookie,
    output logic [127:0]          client_peer_ip,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {IDLE, BODY, DISCARD, EMIT} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  idx_reg, idx_next, idx_inc;
    logic        accept, hs_word0, capture;

    // Shadow words hold body words 4..15 (entry 0 = word 4); out_reg holds the emitted copy.
    logic [31:0] shadow_reg  [12];
    logic [31:0] shadow_next [12];
    logic [31:0] out_reg     [12];

    assign in_ready = rst || (state_reg != EMIT);
    assign accept   = in_valid && in_ready;
    assign hs_word0 = in_data[31] && (in_data[30:16] == 15'd0);
    assign idx_inc  = (idx_reg == 5'd16) ? 5'd16 : idx_reg + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 5'd0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE, BODY, DISCARD: begin
                if (accept) begin
                    if (in_sop) begin
                        // A sop always restarts parsing, aborting any packet in flight.
                        idx_next = 5'd1;
                        if (in_eop)
                            state_next = IDLE;
                        else if (hs_word0)
                            state_next = BODY;
                        else
                            state_next = DISCARD;
                    end else if (state_reg == BODY) begin
                        capture  = 1'b1;
                        idx_next = idx_inc;
                        if (in_eop)
                            state_next = (idx_reg >= 5'd15) ? EMIT : IDLE;
                    end else if (state_reg == DISCARD) begin
                        idx_next = idx_inc;
                        if (in_eop)
                            state_next = IDLE;
                    end
                end
            end
            EMIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_word
            assign shadow_next[gi] = (capture && idx_reg == 5'(gi + 4)) ? in_data : shadow_reg[gi];

            // Outputs load on entry to EMIT so they are valid alongside the strobe.
            always_ff @(posedge clk) begin
                if (rst) begin
                    shadow_reg[gi] <= 32'd0;
                    out_reg[gi]    <= 32'd0;
                end else begin
                    shadow_reg[gi] <= shadow_next[gi];
                    if (state_next == EMIT)
                        out_reg[gi] <= shadow_next[gi];
                end
            end
        end
    endgenerate

    assign client_type_en   = (state_reg == EMIT);
    assign client_version   = out_reg[0];
    assign client_sock_type = out_reg[1];
    assign client_isn       = out_reg[2];
    assign client_mss       = out_reg[3];
    assign client_flow_win  = out_reg[4];
    assign client_type      = out_reg[5];
    assign client_sock_id   = out_reg[6];
    assign client_cookie    = out_reg[7];
    assign client_peer_ip   = {out_reg[8], out_reg[9], out_reg[10], out_reg[11]};

`ifdef UDT_HS_DROP_CNT_EN
    logic [1:0]            drop_inc;
    logic [DROP_CNT_W:0]   drop_sum;
    logic [DROP_CNT_W-1:0] drop_cnt_reg;

    // A sop can both abort a BODY packet and be a one-word handshake itself.
    always_comb begin
        drop_inc = 2'd0;
        if (accept && state_reg != EMIT) begin
            if (in_sop) begin
                if (state_reg == BODY)
                    drop_inc = drop_inc + 2'd1;
                if (hs_word0 && in_eop)
                    drop_inc = drop_inc + 2'd1;
            end else if (state_reg == BODY && in_eop && idx_reg < 5'd15) begin
                drop_inc = 2'd1;
            end
        end
        drop_sum = {1'b0, drop_cnt_reg} + (DROP_CNT_W + 1)'(drop_inc);
    end

    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt_reg <= '0;
        else if (drop_sum[DROP_CNT_W])
            drop_cnt_reg <= '1;
        else
            drop_cnt_reg <= drop_sum[DROP_CNT_W-1:0];
    end

    assign drop_cnt = drop_cnt_reg;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_udt_hs_parser.sv
// Directed self-checking bench for udt_hs_parser; drop_cnt expectations
// follow UDT_HS_DROP_CNT_EN.
module tb_udt_hs_parser;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [31:0]  in_data;
    logic         in_sop;
    logic         in_eop;
    logic         in_ready;
    logic         client_type_en;
    logic [31:0]  client_type, client_version, client_sock_type, client_isn;
    logic [31:0]  client_mss, client_flow_win, client_sock_id, client_cookie;
    logic [127:0] client_peer_ip;
    logic [15:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int exp_drop = 0;
    logic [31:0] pkt [20];

    udt_hs_parser #(.DROP_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
        .client_type_en(client_type_en), .client_type(client_type),
        .client_version(client_version), .client_sock_type(client_sock_type),
        .client_isn(client_isn), .client_mss(client_mss),
        .client_flow_win(client_flow_win), .client_sock_id(client_sock_id),
        .client_cookie(client_cookie), .client_peer_ip(client_peer_ip),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (client_type_en) pulses++;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int drop_model();
`ifdef UDT_HS_DROP_CNT_EN
        return exp_drop;
`else
        return 0;
`endif
    endfunction

    // Word i of packet "tag" is 0xC0DE_<tag><i>; word 0 is a handshake header.
    task automatic fill(input logic [7:0] tag);
        for (int i = 0; i < 20; i++) pkt[i] = 32'hC0DE_0000 | {16'h0, tag, 8'(i)};
        pkt[0] = 32'h8000_0000 | {24'h0, tag};
    endtask

    task automatic send_word(input logic [31:0] d, input logic sop, input logic eop);
        in_valid = 1'b1; in_data = d; in_sop = sop; in_eop = eop;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    endtask

    task automatic send_pkt(input int n, input bit with_eop);
        for (int i = 0; i < n; i++) send_word(pkt[i], i == 0, with_eop && (i == n - 1));
        $display("pkt words=%0d word0=%08h eop=%0d drop_cnt=%0d pulses=%0d",
                 n, pkt[0], with_eop, drop_cnt, pulses);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_sop = 1'b0; in_eop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_en", client_type_en, 0);
        rst = 1'b0;
        idle_cycle();
        check("rst_type", client_type, 0);
        check("rst_peer", client_peer_ip, 0);
        check("rst_drop", drop_cnt, 0);

        // 16-word handshake, type 0, cookie 0x12345678
        fill(8'h01); pkt[9] = 32'h0; pkt[11] = 32'h1234_5678;
        send_pkt(16, 1);
        check("t1_en", client_type_en, 1);
        check("t1_ready_emit", in_ready, 0);
        check("t1_type", client_type, 32'h0);
        check("t1_cookie", client_cookie, 32'h1234_5678);
        check("t1_version", client_version, 32'hC0DE_0104);
        check("t1_mss", client_mss, 32'hC0DE_0107);
        check("t1_peer", client_peer_ip, 128'hC0DE010C_C0DE010D_C0DE010E_C0DE010F);
        idle_cycle();
        check("t1_en_off", client_type_en, 0);
        check("t1_ready", in_ready, 1);
        check("t1_pulses", pulses, 1);

        // 20-word handshake, words 16..19 ignored
        fill(8'h02); pkt[9] = 32'hFFFF_FFFF;
        send_pkt(20, 1);
        check("t2_en", client_type_en, 1);
        check("t2_type", client_type, 32'hFFFF_FFFF);
        check("t2_peer", client_peer_ip, 128'hC0DE020C_C0DE020D_C0DE020E_C0DE020F);
        idle_cycle();
        check("t2_pulses", pulses, 2);

        // data packet: no pulse, nothing changes
        fill(8'h03); pkt[0] = 32'h0000_0001;
        send_pkt(16, 1);
        check("t3_en", client_type_en, 0);
        idle_cycle();
        check("t3_pulses", pulses, 2);
        check("t3_drop", drop_cnt, drop_model());
        check("t3_cookie", client_cookie, 32'hC0DE_020B);

        // truncated at word 10
        fill(8'h04);
        send_pkt(11, 1);
        exp_drop++;
        check("t4_en", client_type_en, 0);
        check("t4_drop", drop_cnt, drop_model());
        check("t4_sock_id", client_sock_id, 32'hC0DE_020A);

        // boundary: eop at index 14 is still short
        fill(8'h07);
        send_pkt(15, 1);
        exp_drop++;
        check("t5_en", client_type_en, 0);
        check("t5_drop", drop_cnt, drop_model());
        check("t5_type", client_type, 32'hFFFF_FFFF);

        // single-word handshake
        fill(8'h08);
        send_pkt(1, 1);
        exp_drop++;
        check("t6_drop", drop_cnt, drop_model());
        idle_cycle();
        check("t6_pulses", pulses, 2);

        // sop at word 7 aborts, second packet emitted
        fill(8'h05);
        send_pkt(7, 0);
        fill(8'h06); pkt[9] = 32'h0;
        send_pkt(16, 1);
        exp_drop++;
        check("t7_en", client_type_en, 1);
        check("t7_drop", drop_cnt, drop_model());
        check("t7_type", client_type, 32'h0);
        check("t7_sock_id", client_sock_id, 32'hC0DE_060A);
        check("t7_cookie", client_cookie, 32'hC0DE_060B);
        idle_cycle();
        check("t7_pulses", pulses, 3);

        // reset during word 8, stray words, then a full handshake
        fill(8'h09);
        send_pkt(8, 0);
        rst = 1'b1; in_valid = 1'b1; in_data = pkt[8];
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        exp_drop = 0;
        check("t8_type", client_type, 0);
        check("t8_cookie", client_cookie, 0);
        check("t8_peer", client_peer_ip, 0);
        check("t8_drop", drop_cnt, 0);
        send_word(32'h8000_0000, 1'b0, 1'b0);
        send_word(32'h1111_1111, 1'b0, 1'b1);
        idle_cycle();
        check("t8_stray_pulses", pulses, 3);
        check("t8_stray_type", client_type, 0);
        fill(8'h0A);
        send_pkt(16, 1);
        check("t8_en", client_type_en, 1);
        check("t8_new_type", client_type, 32'hC0DE_0A09);
        check("t8_new_cookie", client_cookie, 32'hC0DE_0A0B);
        check("t8_new_drop", drop_cnt, drop_model());
        idle_cycle();
        check("t8_pulses", pulses, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/udt_hs_parser.md
UDT_HS_PARSER -- requirements
Module: udt_hs_parser

Interface
REQ-001 Parameter DROP_CNT_W, default 16, width of the dropped-handshake counter.
REQ-002 clk  input  1  sole clock; all logic samples on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  input word valid.
REQ-005 in_data  input  32  received UDT packet word, big-endian word order.
REQ-006 in_sop  input  1  first word of packet; qualified by in_valid.
REQ-007 in_eop  input  1  last word of packet; qualified by in_valid.
REQ-008 in_ready  output  1  parser accepts a word when in_valid and in_ready are both high.
REQ-009 client_type_en  output  1  one-cycle strobe: a complete handshake was parsed; feeds the listen stage.
REQ-010 client_type  output  32  handshake connection type (body word 9).
REQ-011 client_version, client_sock_type, client_isn, client_mss, client_flow_win, client_sock_id, client_cookie  output  32 each  body words 4, 5, 6, 7, 8, 10 and 11.
REQ-012 client_peer_ip  output  128  words 12..15; word 12 in bits [127:96].
REQ-013 drop_cnt  output  DROP_CNT_W  count of truncated or aborted handshake packets.

Function
REQ-014 The word index counts accepted words from 0 at in_sop and saturates at 16.
REQ-015 A packet is a handshake when word 0 has bit31=1 and bits[30:16]=0.
REQ-016 FSM states are IDLE, BODY, DISCARD and EMIT; the reset state is IDLE.
REQ-017 IDLE: non-sop words are ignored; a sop handshake word 0 goes to BODY; a sop non-handshake word goes to DISCARD.
REQ-018 IDLE/BODY: a single-word handshake packet (sop and eop together) goes to IDLE and increments drop_cnt.
REQ-019 BODY: words 4..15 are captured into shadow registers; words after 15 are ignored.
REQ-020 BODY: eop at index ≥15 goes to EMIT; eop at index <15 goes to IDLE and increments drop_cnt.
REQ-021 DISCARD: words are consumed without capture; eop goes to IDLE; no drop is counted.
REQ-022 In BODY or DISCARD, an accepted in_sop aborts the current packet and is processed as word 0 of a new packet in the same cycle; drop_cnt increments only if the aborted packet was in BODY.
REQ-023 EMIT lasts exactly one cycle, then returns to IDLE.
REQ-024 In EMIT, client_type_en=1, all client_* outputs load from the shadow registers, and in_ready=0.
REQ-025 in_ready=1 in every state except EMIT.
REQ-026 Latency: client_type_en rises on the first clock edge after the accepted eop beat.
REQ-027 client_* outputs hold their value until the next EMIT.
REQ-028 A handshake that is not emitted never changes the client_* outputs.
REQ-029 drop_cnt saturates at all-ones and does not wrap.
REQ-030 A drop event and an emit cannot occur in the same cycle.

Reset
REQ-031 While rst=1 at a clock edge: FSM goes to IDLE, index=0, and every output is 0 except in_ready.
REQ-032 During reset, in_ready=1.
REQ-033 Reset asserted mid-packet discards that packet without counting a drop.
REQ-034 After reset, words before the next in_sop are ignored.

Configuration
REQ-035 Macro UDT_HS_DROP_CNT_EN defined: drop_cnt is implemented as specified in REQ-018, REQ-020, REQ-022 and REQ-029.
REQ-036 Macro UDT_HS_DROP_CNT_EN undefined: the drop_cnt port still exists, is tied to 0, and has no counter register; all other behaviour is unchanged.

Verification
REQ-037 Stimulus: 16-word packet with word0=0x8000_0000, word9=0x0000_0000, word11=0x1234_5678. Response: one client_type_en pulse on the cycle after eop, client_type=0, client_cookie=0x1234_5678.
REQ-038 Stimulus: 20-word handshake with word9=0xFFFF_FFFF. Response: a single pulse after eop, client_type=0xFFFF_FFFF, words 16..19 ignored.
REQ-039 Stimulus: 16-word data packet with word0=0x0000_0001. Response: no pulse, drop_cnt unchanged, client_* unchanged.
REQ-040 Stimulus: handshake ending with eop at word 10. Response: no pulse, drop_cnt goes 0→1, client_* unchanged.
REQ-041 Stimulus: in_sop at word 7 of a handshake, followed by a complete valid handshake with word9=0. Response: drop_cnt +1 and exactly one pulse carrying the second packet's fields.
REQ-042 Stimulus: rst pulsed during word 8, then a full handshake. Response: outputs 0 after reset, drop_cnt 0, one pulse for the new packet.
